// File: rtl/npu_seq_ctrl.sv
// Autonomous NPU layer sequencer: conv1, CHAN conv2 passes, streamed fc1 groups, fc2 result.
// Weight loads go through a level-held req/ack handshake; a watchdog traps stalled datapath states.
module npu_seq_ctrl #(
    parameter int CHAN       = 10,
    parameter int CONV1_LAST = 182,
    parameter int CONV2_LAST = 132,
    parameter int FC1_GROUPS = 330,
    parameter int TMO_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        wreq,
    output logic [1:0]  wkind,
    output logic [8:0]  widx,
    input  logic        wack,
    output logic        conv_trigger,
    output logic        conv_layer,
    output logic        conv_clear,
    input  logic [7:0]  conv_addr,
    output logic        sum_clear,
    output logic        fcn_start,
    output logic        fc1_next,
    input  logic        fc1_valid,
    input  logic        fcn_done,
    input  logic [23:0] fcn_logit,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [23:0] result,
    output logic [2:0]  phase
);
    localparam int WDW = $clog2(TMO_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        CONV    = 3'd2,
        FC_LOAD = 3'd3,
        FC_WAIT = 3'd4,
        FINISH  = 3'd5,
        ERR     = 3'd6
    } state_t;

    state_t         state, state_n;
    logic [8:0]     chan_cnt, chan_cnt_n, grp_cnt, grp_cnt_n, widx_n;
    logic [WDW-1:0] wdog, wdog_n;
    logic [1:0]     wkind_n;
    logic [23:0]    result_n;
    logic           wreq_n, conv_layer_n, err_n;
    logic           conv_trigger_n, conv_clear_n, sum_clear_n, fcn_start_n, fc1_next_n, done_n;
    logic           pass_end, watched;

    assign pass_end = conv_layer ? (conv_addr == 8'(CONV2_LAST)) : (conv_addr == 8'(CONV1_LAST));
    assign watched  = state inside {CONV, FC_WAIT, FINISH};
    assign busy     = (state != IDLE);
    assign phase    = state;

    always_comb begin
        state_n        = state;
        chan_cnt_n     = chan_cnt;
        grp_cnt_n      = grp_cnt;
        wreq_n         = wreq;
        wkind_n        = wkind;
        widx_n         = widx;
        conv_layer_n   = conv_layer;
        err_n          = err;
        result_n       = result;
        conv_trigger_n = 1'b0;
        conv_clear_n   = 1'b0;
        sum_clear_n    = 1'b0;
        fcn_start_n    = 1'b0;
        fc1_next_n     = 1'b0;
        done_n         = 1'b0;
        // Abort dominates everything, including a same-cycle start
        if (abort && state != IDLE) begin
            state_n      = IDLE;
            conv_clear_n = 1'b1;
            wreq_n       = 1'b0;
            conv_layer_n = 1'b0;
            err_n        = 1'b0;
        end else if (abort) begin
            err_n = 1'b0;
        end else if (fcn_done && state != IDLE && state != FINISH) begin
            state_n = ERR;
            wreq_n  = 1'b0;
            err_n   = 1'b1;
        end else if (watched && wdog == WDW'(TMO_CYCLES - 1)) begin
            state_n = ERR;
            wreq_n  = 1'b0;
            err_n   = 1'b1;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state_n      = LOAD_W;
                    sum_clear_n  = 1'b1;
                    conv_layer_n = 1'b0;
                    chan_cnt_n   = '0;
                    wkind_n      = 2'd0;
                    widx_n       = '0;
                    wreq_n       = 1'b1;
                end
                LOAD_W: if (wreq && wack) begin
                    state_n        = CONV;
                    wreq_n         = 1'b0;
                    conv_trigger_n = 1'b1;
                end
                CONV: if (pass_end) begin
                    conv_clear_n = 1'b1;
                    wreq_n       = 1'b1;
                    if (!conv_layer) begin
                        state_n      = LOAD_W;
                        conv_layer_n = 1'b1;
                        wkind_n      = 2'd1;
                        widx_n       = '0;
                    end else if (chan_cnt < 9'(CHAN - 1)) begin
                        state_n    = LOAD_W;
                        chan_cnt_n = chan_cnt + 9'd1;
                        widx_n     = chan_cnt + 9'd1;
                    end else begin
                        state_n     = FC_LOAD;
                        fcn_start_n = 1'b1;
                        grp_cnt_n   = '0;
                        wkind_n     = 2'd2;
                        widx_n      = '0;
                    end
                end
                FC_LOAD: if (wreq && wack) begin
                    state_n    = FC_WAIT;
                    wreq_n     = 1'b0;
                    fc1_next_n = 1'b1;
                end
                FC_WAIT: if (fc1_valid) begin
                    if (grp_cnt < 9'(FC1_GROUPS - 1)) begin
                        state_n   = FC_LOAD;
                        grp_cnt_n = grp_cnt + 9'd1;
                        widx_n    = grp_cnt + 9'd1;
                        wreq_n    = 1'b1;
                    end else begin
                        state_n = FINISH;
                    end
                end
                FINISH: if (fcn_done) begin
                    state_n  = IDLE;
                    result_n = fcn_logit;
                    done_n   = 1'b1;
                end
                default: ;
            endcase
        end
        // Count only while staying in a watched state; any entry restarts at zero
        wdog_n = (state_n != state || !watched) ? '0 : wdog + WDW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            chan_cnt     <= '0;
            grp_cnt      <= '0;
            wdog         <= '0;
            wreq         <= 1'b0;
            wkind        <= 2'd0;
            widx         <= '0;
            conv_layer   <= 1'b0;
            err          <= 1'b0;
            result       <= '0;
            conv_trigger <= 1'b0;
            conv_clear   <= 1'b0;
            sum_clear    <= 1'b0;
            fcn_start    <= 1'b0;
            fc1_next     <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            chan_cnt     <= chan_cnt_n;
            grp_cnt      <= grp_cnt_n;
            wdog         <= wdog_n;
            wreq         <= wreq_n;
            wkind        <= wkind_n;
            widx         <= widx_n;
            conv_layer   <= conv_layer_n;
            err          <= err_n;
            result       <= result_n;
            conv_trigger <= conv_trigger_n;
            conv_clear   <= conv_clear_n;
            sum_clear    <= sum_clear_n;
            fcn_start    <= fcn_start_n;
            fc1_next     <= fc1_next_n;
            done         <= done_n;
        end
    end
endmodule

// File: tb/tb_npu_seq_ctrl.sv
// Scoreboard bench for npu_seq_ctrl: a sequence model queues expected events, a monitor pops them.
module tb_npu_seq_ctrl;
    localparam int CHAN = 2, FC1_GROUPS = 3, TMO = 16, C1L = 182, C2L = 132;
    localparam int EV_SCLR = 0, EV_CCLR = 1, EV_FSTART = 2, EV_WREQ = 3, EV_TRIG = 4,
                   EV_FNEXT = 5, EV_DONE = 6;

    logic        clk, rst, start, abort, wack, fc1_valid, fcn_done;
    logic [7:0]  conv_addr;
    logic [23:0] fcn_logit;
    logic        wreq, conv_trigger, conv_layer, conv_clear, sum_clear, fcn_start, fc1_next;
    logic        busy, done, err;
    logic [1:0]  wkind;
    logic [8:0]  widx;
    logic [23:0] result;
    logic [2:0]  phase;

    npu_seq_ctrl #(.CHAN(CHAN), .CONV1_LAST(C1L), .CONV2_LAST(C2L),
                   .FC1_GROUPS(FC1_GROUPS), .TMO_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .wreq(wreq), .wkind(wkind), .widx(widx), .wack(wack),
        .conv_trigger(conv_trigger), .conv_layer(conv_layer), .conv_clear(conv_clear),
        .conv_addr(conv_addr), .sum_clear(sum_clear), .fcn_start(fcn_start),
        .fc1_next(fc1_next), .fc1_valid(fc1_valid), .fcn_done(fcn_done),
        .fcn_logit(fcn_logit), .busy(busy), .done(done), .err(err),
        .result(result), .phase(phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int kind; int a; int b; } ev_t;
    ev_t exp_q[$];
    int  n_chk = 0, n_pass = 0;
    bit  mon_en = 1'b0;
    bit  wreq_q = 1'b0;

    task automatic chk_eq(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic void push(input int k, input int a = 0, input int b = 0);
        ev_t e;
        e.kind = k; e.a = a; e.b = b;
        exp_q.push_back(e);
    endfunction

    // Reference: the event stream of one inference, from start up to FC_LOAD entry
    function automatic void model_conv();
        push(EV_SCLR); push(EV_WREQ, 0, 0); push(EV_TRIG, 0);
        for (int c = 0; c < CHAN; c++) begin
            push(EV_CCLR); push(EV_WREQ, 1, c); push(EV_TRIG, 1);
        end
        push(EV_CCLR); push(EV_FSTART); push(EV_WREQ, 2, 0);
    endfunction

    function automatic void model_fc(input int logit);
        for (int g = 0; g < FC1_GROUPS; g++) begin
            push(EV_FNEXT);
            if (g < FC1_GROUPS - 1) push(EV_WREQ, 2, g + 1);
        end
        push(EV_DONE, logit);
    endfunction

    task automatic got(input int k, input int a, input int b);
        ev_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got kind %0d a %0d b %0d, expected none", k, a, b);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind == k && e.a == a && e.b == b) n_pass++;
        else $display("FAIL event: got kind %0d a %0d b %0d, expected kind %0d a %0d b %0d",
                      k, a, b, e.kind, e.a, e.b);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sum_clear)       got(EV_SCLR, 0, 0);
            if (conv_clear)      got(EV_CCLR, 0, 0);
            if (fcn_start)       got(EV_FSTART, 0, 0);
            if (wreq && !wreq_q) got(EV_WREQ, int'(wkind), int'(widx));
            if (conv_trigger)    got(EV_TRIG, int'(conv_layer), 0);
            if (fc1_next)        got(EV_FNEXT, 0, 0);
            if (done)            got(EV_DONE, int'($signed(result)), 0);
        end
        wreq_q = wreq;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic bit sig(input int s);
        case (s)
            0: return wreq;
            1: return conv_trigger;
            2: return fc1_next;
            3: return done;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int s, input int budget, input string name);
        int n = 0;
        while (!sig(s) && n < budget) begin tick(); n++; end
        chk_eq(name, sig(s), 1);
    endtask

    function automatic logic [7:0] rand_addr();
        logic [7:0] v;
        do v = 8'($urandom_range(0, 255)); while (v == 8'(C1L) || v == 8'(C2L));
        return v;
    endfunction

    task automatic serve_wreq(input int d, input bit inj, input int gexp);
        wait_for(0, 4, "wreq");
        for (int i = 0; i < d; i++) begin
            fc1_valid = inj && (i == 0);
            tick();
            fc1_valid = 1'b0;
            chk_eq("wreq_held", {wreq, conv_trigger, fc1_next}, 3'b100);
            if (inj && i == 0) begin
                chk_eq("fv_ignored_phase", phase, 3);
                chk_eq("fv_ignored_widx", widx, gexp);
            end
        end
        wack = 1'b1; tick(); wack = 1'b0;
    endtask

    // dly < 0 selects random wack latency per request
    task automatic run_inf(input int dly, input int logit, input bit inj_start,
                           input bit inj_fv, input bit stop_fc);
        int d, n;
        model_conv();
        if (!stop_fc) model_fc(logit);
        start = 1'b1; tick(); start = 1'b0;
        chk_eq("wreq_after_start", wreq, 1);
        for (int p = 0; p <= CHAN; p++) begin
            d = (dly < 0) ? int'($urandom_range(0, 4)) : dly;
            serve_wreq(d, 1'b0, 0);
            wait_for(1, 4, "conv_trigger");
            n = $urandom_range(1, 6);
            repeat (n) begin
                conv_addr = rand_addr();
                wack = ($urandom_range(0, 3) == 0);
                tick();
            end
            wack = 1'b0;
            conv_addr = 8'((p == 0) ? C2L : C1L); tick();
            conv_addr = 8'((p == 0) ? C1L : C2L); tick();
            conv_addr = rand_addr();
        end
        if (stop_fc) begin
            wait_for(0, 4, "wreq_fc");
            return;
        end
        for (int g = 0; g < FC1_GROUPS; g++) begin
            d = (dly < 0) ? int'($urandom_range(0, 4)) : dly;
            if (inj_fv && g == 1 && d == 0) d = 1;
            serve_wreq(d, inj_fv && g == 1, g);
            wait_for(2, 4, "fc1_next");
            n = $urandom_range(1, 6);
            repeat (n) tick();
            if (inj_start && g == 1) begin
                start = 1'b1; tick(); start = 1'b0;
                chk_eq("start_ignored_phase", phase, 4);
            end
            fc1_valid = 1'b1; tick(); fc1_valid = 1'b0;
        end
        n = $urandom_range(1, 6);
        repeat (n) tick();
        fcn_logit = 24'(logit); fcn_done = 1'b1; tick(); fcn_done = 1'b0;
        wait_for(3, 2, "done");
        chk_eq("busy_after_done", busy, 0);
        chk_eq("result", $signed(result), logit);
        tick();
        chk_eq("done_one_cycle", done, 0);
    endtask

    task automatic to_conv();
        push(EV_SCLR); push(EV_WREQ, 0, 0); push(EV_TRIG, 0);
        start = 1'b1; tick(); start = 1'b0;
        serve_wreq(1, 1'b0, 0);
        wait_for(1, 4, "conv_trigger");
    endtask

    task automatic do_abort(input string name);
        push(EV_CCLR);
        abort = 1'b1; tick(); abort = 1'b0;
        chk_eq({name, "_err"}, err, 0);
        chk_eq({name, "_phase"}, phase, 0);
        repeat (3) tick();
    endtask

    initial begin
        int lg;
        rst = 1'b1; start = 1'b0; abort = 1'b0; wack = 1'b0; conv_addr = 8'd0;
        fc1_valid = 1'b0; fcn_done = 1'b0; fcn_logit = 24'd0;
        repeat (3) tick();
        chk_eq("rst_ctrl", {wreq, wkind, widx, conv_trigger, conv_layer, conv_clear, sum_clear,
                            fcn_start, fc1_next, busy, done, err, phase}, 0);
        chk_eq("rst_result", result, 0);
        rst = 1'b0; mon_en = 1'b1; tick();
        chk_eq("idle_phase", phase, 0);

        run_inf(0, -5, 1'b0, 1'b0, 1'b0);
        chk_eq("result_raw", result, 24'hFFFFFB);
        run_inf(7, -5, 1'b0, 1'b0, 1'b0);

        // Watchdog: conv_addr never reaches the end of the pass
        to_conv();
        for (int k = 1; k <= TMO; k++) begin
            conv_addr = rand_addr(); tick();
            if (k == TMO - 1) chk_eq("wdog_not_early", err, 0);
        end
        chk_eq("wdog_err", err, 1);
        chk_eq("wdog_phase", phase, 6);
        chk_eq("err_busy", busy, 1);
        chk_eq("err_wreq", wreq, 0);
        do_abort("wdog_abort");

        run_inf(-1, 12345, 1'b1, 1'b0, 1'b0);
        to_conv();
        push(EV_CCLR);
        abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
        chk_eq("abort_start_phase", phase, 0);
        repeat (3) tick();
        abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
        chk_eq("idle_abort_start", {phase, wreq}, 0);
        repeat (2) tick();

        to_conv();
        fcn_done = 1'b1; tick(); fcn_done = 1'b0;
        chk_eq("proto_err", err, 1);
        chk_eq("proto_phase", phase, 6);
        do_abort("proto_abort");
        chk_eq("result_kept", $signed(result), 12345);

        run_inf(-1, 0, 1'b0, 1'b0, 1'b1);
        chk_eq("fc_load_phase", phase, 3);
        rst = 1'b1; tick(); rst = 1'b0;
        chk_eq("midrst_ctrl", {wreq, wkind, widx, conv_trigger, conv_layer, conv_clear, sum_clear,
                               fcn_start, fc1_next, busy, done, err, phase}, 0);
        chk_eq("midrst_result", result, 0);
        chk_eq("midrst_queue", exp_q.size(), 0);
        tick();

        run_inf(2, -777, 1'b0, 1'b1, 1'b0);
        repeat (6) begin
            lg = int'($urandom_range(0, 24'hFFFFFF)) - 8388608;
            run_inf(-1, lg, 1'b0, 1'b0, 1'b0);
        end
        repeat (5) tick();
        chk_eq("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
